// File: rtl/bus_matrix_rr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bus_matrix_rr_pkg
//  Purpose  : Shared bus definitions for the round-robin bus matrix:
//             strobe/enable polarities, read/write encoding, default widths,
//             arbiter state type and a clog2 helper.
//  Revision : 1.0  initial parametrised release
// ============================================================================
package bus_matrix_rr_pkg;

  // Active-low enable polarity used by all strobes, selects and grants
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Read/write flag encoding
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  // Default bus widths
  localparam int WORD_ADDR_W = 32;
  localparam int WORD_DATA_W = 32;

  // Arbiter ownership state
  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  // Ceiling log2 with a floor of 1 so single-entry fields still get one bit
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Round-robin arbiter with a registered one-hot grant. The grant
//             is held while the owner keeps requesting; on release the next
//             requester (searched from ptr_i+1) is granted at the same edge.
//  Revision : 1.0  initial parametrised release
// ============================================================================
module rr_arbiter
  import bus_matrix_rr_pkg::*;
#(
  parameter  int NUM_M = 4,
  localparam int MW    = clog2_min1(NUM_M)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NUM_M-1:0] req_i,      // active-high request vector
  input  logic [MW-1:0]    ptr_i,      // index of the most recent grant
  output logic [NUM_M-1:0] grant_o,    // registered one-hot grant
  output logic             upd_o,      // a new grant is issued at this edge
  output logic [MW-1:0]    upd_idx_o   // index of that new grant
);

  arb_state_e       state_q, state_d;
  logic [NUM_M-1:0] grant_q, grant_d;
  logic             win_vld;
  logic [MW-1:0]    win_idx;
  logic [MW-1:0]    cand;
  logic             w_hold;

  // Owner keeps the bus as long as its own request stays asserted
  assign w_hold    = |(grant_q & req_i);
  assign grant_o   = grant_q;
  assign upd_idx_o = win_idx;

  // Find the first requester after ptr_i; the pointer itself comes last
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = NUM_M; i >= 1; i--) begin
      cand = MW'((int'(ptr_i) + i) % NUM_M);
      if (req_i[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Ownership state and grant register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Next grant: hold, hand over without a gap, or fall back to idle
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    upd_o   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (win_vld) begin
          upd_o   = 1'b1;
          grant_d = {{(NUM_M-1){1'b0}}, 1'b1} << win_idx;
          state_d = ARB_OWNED;
        end
      end
      ARB_OWNED: begin
        if (!w_hold) begin
          if (win_vld) begin
            upd_o   = 1'b1;
            grant_d = {{(NUM_M-1){1'b0}}, 1'b1} << win_idx;
          end else begin
            grant_d = '0;
            state_d = ARB_IDLE;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bus_matrix_rr.sv
`default_nettype none
// ============================================================================
//  Module   : bus_matrix_rr
//  Purpose  : NUM_M-master / NUM_S-slave bus matrix. Round-robin ownership,
//             owner address decode to active-low chip selects, read data and
//             ready return, error response for unmapped slaves and an
//             optional wait-state timeout.
//  Revision : 1.0  initial parametrised release
// ============================================================================
module bus_matrix_rr
  import bus_matrix_rr_pkg::*;
#(
  parameter int NUM_M   = 4,
  parameter int NUM_S   = 8,
  parameter int ADDR_W  = WORD_ADDR_W,
  parameter int DATA_W  = WORD_DATA_W,
  parameter int SEL_LO  = 29,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_M-1:0]        m_req_,
  input  logic [NUM_M*ADDR_W-1:0] m_addr,
  input  logic [NUM_M-1:0]        m_as_,
  input  logic [NUM_M-1:0]        m_rw,
  input  logic [NUM_M*DATA_W-1:0] m_wr_data,
  output logic [NUM_M-1:0]        m_grnt_,
  output logic [DATA_W-1:0]       m_rd_data,
  output logic                    m_rdy_,
  output logic                    m_err,
  output logic [ADDR_W-1:0]       s_addr,
  output logic                    s_as_,
  output logic                    s_rw,
  output logic [DATA_W-1:0]       s_wr_data,
  output logic [NUM_S-1:0]        s_cs_,
  input  logic [NUM_S*DATA_W-1:0] s_rd_data,
  input  logic [NUM_S-1:0]        s_rdy_
);

  localparam int            MW       = clog2_min1(NUM_M);
  localparam int            SW       = clog2_min1(NUM_S);
  localparam int            CW       = clog2_min1(TIMEOUT + 1);
  localparam logic [SW:0]   NUM_S_X  = (SW+1)'(NUM_S);

  logic [NUM_M-1:0]  w_grant;
  logic              w_upd;
  logic [MW-1:0]     w_upd_idx;
  logic [MW-1:0]     ptr_q, ptr_d;
  logic              w_owner_vld;
  logic [MW-1:0]     w_owner;
  logic [SW-1:0]     w_idx;
  logic              w_mapped;
  logic              w_unmapped;
  logic              w_waiting;
  logic              w_tmo_hit;
  logic [DATA_W-1:0] w_slv_rd;
  logic              w_slv_rdy_;

  rr_arbiter #(
    .NUM_M (NUM_M)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_i     (~m_req_),
    .ptr_i     (ptr_q),
    .grant_o   (w_grant),
    .upd_o     (w_upd),
    .upd_idx_o (w_upd_idx)
  );

  assign m_grnt_     = ~w_grant;
  assign w_owner_vld = |w_grant;
  // The last-grant pointer always equals the current owner while one exists
  assign w_owner     = ptr_q;
  assign ptr_d       = w_upd ? w_upd_idx : ptr_q;

  // Last-grant pointer; reset value makes master 0 the first in line
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= MW'(NUM_M - 1);
    else       ptr_q <= ptr_d;
  end

  // Route the owner's address phase to the slave side; idle bus is quiet
  always_comb begin
    s_as_     = DISABLE_;
    s_addr    = '0;
    s_rw      = READ;
    s_wr_data = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (w_owner_vld && (w_owner == MW'(i))) begin
        s_as_     = m_as_[i];
        s_addr    = m_addr[i*ADDR_W +: ADDR_W];
        s_rw      = m_rw[i];
        s_wr_data = m_wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_idx      = s_addr[SEL_LO +: SW];
  assign w_mapped   = w_owner_vld && ({1'b0, w_idx} < NUM_S_X);
  assign w_unmapped = w_owner_vld && (s_as_ == ENABLE_) && !w_mapped;
  assign w_waiting  = w_mapped && (s_as_ == ENABLE_) && w_slv_rdy_;

  // Chip-select decode and selected slave's data/ready
  always_comb begin
    s_cs_      = '1;
    w_slv_rd   = '0;
    w_slv_rdy_ = DISABLE_;
    for (int i = 0; i < NUM_S; i++) begin
      if (w_owner_vld && (w_idx == SW'(i))) begin
        s_cs_[i]   = ENABLE_;
        w_slv_rd   = s_rd_data[i*DATA_W +: DATA_W];
        w_slv_rdy_ = s_rdy_[i];
      end
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_timeout
      logic [CW-1:0] cnt_q, cnt_d;

      assign w_tmo_hit = w_waiting && (cnt_q == CW'(TIMEOUT));

      // Count wait cycles of the current access; restart on any completion
      always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (w_upd || !w_waiting || w_tmo_hit) cnt_d = '0;
      end

      // Wait-state counter register
      always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end
    end else begin : g_no_timeout
      assign w_tmo_hit = 1'b0;
    end
  endgenerate

  // Response to the masters; error responses terminate with ready low
  always_comb begin
    m_rd_data = w_slv_rd;
    m_rdy_    = w_slv_rdy_;
    m_err     = 1'b0;
    if (w_unmapped || w_tmo_hit) begin
      m_rdy_ = ENABLE_;
      m_err  = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_matrix_rr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_matrix_rr
//  Purpose  : Bench for bus_matrix_rr. Two instances share master and slave
//             stimulus: u_dut0 (NUM_S=8, TIMEOUT=255) and u_dut1 (NUM_S=5,
//             TIMEOUT=4). Directed scenarios followed by random traffic,
//             every cycle compared against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bus_matrix_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [3:0]   m_req_, m_as_, m_rw;
  logic [127:0] m_addr, m_wr_data;
  logic [255:0] s_rd_data;
  logic [7:0]   s_rdy_;

  logic [3:0]  g0, g1;
  logic [31:0] rd0, rd1, sa0, sa1, wd0, wd1;
  logic        rdy0, rdy1, err0, err1, as0, as1, rw0, rw1;
  logic [7:0]  cs0;
  logic [4:0]  cs1;

  bus_matrix_rr #(.NUM_M(4), .NUM_S(8), .ADDR_W(32), .DATA_W(32), .SEL_LO(29), .TIMEOUT(255)) u_dut0 (
    .clk(clk), .reset(reset), .m_req_(m_req_), .m_addr(m_addr), .m_as_(m_as_), .m_rw(m_rw),
    .m_wr_data(m_wr_data), .m_grnt_(g0), .m_rd_data(rd0), .m_rdy_(rdy0), .m_err(err0),
    .s_addr(sa0), .s_as_(as0), .s_rw(rw0), .s_wr_data(wd0), .s_cs_(cs0),
    .s_rd_data(s_rd_data), .s_rdy_(s_rdy_)
  );

  bus_matrix_rr #(.NUM_M(4), .NUM_S(5), .ADDR_W(32), .DATA_W(32), .SEL_LO(29), .TIMEOUT(4)) u_dut1 (
    .clk(clk), .reset(reset), .m_req_(m_req_), .m_addr(m_addr), .m_as_(m_as_), .m_rw(m_rw),
    .m_wr_data(m_wr_data), .m_grnt_(g1), .m_rd_data(rd1), .m_rdy_(rdy1), .m_err(err1),
    .s_addr(sa1), .s_as_(as1), .s_rw(rw1), .s_wr_data(wd1), .s_cs_(cs1),
    .s_rd_data(s_rd_data[159:0]), .s_rdy_(s_rdy_[4:0])
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: owner (-1 = none), last granted master, wait count
  int own [2];
  int last[2];
  int cnt [2];

  logic [3:0]  e_grnt[2];
  logic [31:0] e_rd[2], e_addr[2], e_wd[2];
  logic        e_rdy[2], e_err[2], e_as[2], e_rw[2];
  logic [7:0]  e_cs[2];
  bit          e_wait[2], e_to[2];

  logic [2:0]  ix;
  int          exp_k;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs from the current model state and inputs
  task automatic model_eval(input int n);
    int         ns, tmo, idx;
    logic [31:0] a;
    logic [7:0]  mask;
    bit          mapped;
    ns   = (n == 0) ? 8 : 5;
    tmo  = (n == 0) ? 255 : 4;
    mask = (n == 0) ? 8'hFF : 8'h1F;
    e_grnt[n] = 4'hF; e_as[n] = 1'b1; e_addr[n] = '0; e_rw[n] = 1'b1; e_wd[n] = '0;
    e_cs[n] = mask; e_rd[n] = '0; e_rdy[n] = 1'b1; e_err[n] = 1'b0;
    e_wait[n] = 1'b0; e_to[n] = 1'b0;
    if (own[n] >= 0) begin
      e_grnt[n][own[n]] = 1'b0;
      a         = m_addr[own[n]*32 +: 32];
      e_addr[n] = a;
      e_as[n]   = m_as_[own[n]];
      e_rw[n]   = m_rw[own[n]];
      e_wd[n]   = m_wr_data[own[n]*32 +: 32];
      idx       = int'(a >> 29);
      mapped    = (idx < ns);
      if (mapped) begin
        e_cs[n]  = mask & ~(8'd1 << idx);
        e_rd[n]  = s_rd_data[idx*32 +: 32];
        e_rdy[n] = s_rdy_[idx];
      end
      if (!e_as[n]) begin
        if (!mapped) begin
          e_rdy[n] = 1'b0; e_err[n] = 1'b1;
        end else if (s_rdy_[idx]) begin
          e_wait[n] = 1'b1;
          if (cnt[n] == tmo) begin
            e_to[n] = 1'b1; e_rdy[n] = 1'b0; e_err[n] = 1'b1;
          end
        end
      end
    end
  endtask

  // Model state update at the coming clock edge
  task automatic model_step(input int n);
    int nxt;
    bit changed;
    nxt = -1;
    changed = 1'b0;
    if (own[n] >= 0 && !m_req_[own[n]]) nxt = own[n];
    else begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (last[n] + k) % 4;
        if (nxt < 0 && !m_req_[c]) begin
          nxt = c;
          changed = 1'b1;
        end
      end
    end
    if (reset) begin
      own[n] = -1; last[n] = 3; cnt[n] = 0;
    end else begin
      cnt[n] = (changed || !e_wait[n] || e_to[n]) ? 0 : cnt[n] + 1;
      if (changed) last[n] = nxt;
      own[n] = nxt;
    end
  endtask

  task automatic settle();
    #1;
    for (int n = 0; n < 2; n++) begin
      model_eval(n);
      check($sformatf("d%0d.grnt", n), (n == 0) ? g0 : g1, e_grnt[n]);
      check($sformatf("d%0d.s_as", n), (n == 0) ? as0 : as1, e_as[n]);
      check($sformatf("d%0d.s_addr", n), (n == 0) ? sa0 : sa1, e_addr[n]);
      check($sformatf("d%0d.s_rw", n), (n == 0) ? rw0 : rw1, e_rw[n]);
      check($sformatf("d%0d.s_wd", n), (n == 0) ? wd0 : wd1, e_wd[n]);
      check($sformatf("d%0d.s_cs", n), (n == 0) ? cs0 : {3'b000, cs1}, e_cs[n]);
      check($sformatf("d%0d.rd", n), (n == 0) ? rd0 : rd1, e_rd[n]);
      check($sformatf("d%0d.rdy", n), (n == 0) ? rdy0 : rdy1, e_rdy[n]);
      check($sformatf("d%0d.err", n), (n == 0) ? err0 : err1, e_err[n]);
    end
  endtask

  task automatic advance();
    for (int n = 0; n < 2; n++) model_step(n);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc();
    settle();
    advance();
  endtask

  task automatic go_idle();
    m_req_ = 4'hF;
    m_as_  = 4'hF;
    cyc();
    cyc();
  endtask

  initial begin
    reset = 1'b1;
    m_req_ = 4'hF; m_as_ = 4'hF; m_rw = 4'hF;
    m_addr = '0; m_wr_data = '0; s_rd_data = '0; s_rdy_ = 8'hFF;
    for (int n = 0; n < 2; n++) begin
      own[n] = -1; last[n] = 3; cnt[n] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset values
    settle();
    check("rst_grnt", g0, 4'hF);
    check("rst_as", as0, 1'b1);
    check("rst_rdy", rdy0, 1'b1);
    check("rst_cs", cs0, 8'hFF);
    advance();
    reset = 1'b0;

    // Grant one cycle after request
    m_req_ = 4'b1110;
    settle();
    check("pre_grnt", g0, 4'hF);
    advance();
    settle();
    check("grant_1cyc", g0, 4'b1110);
    advance();
    go_idle();

    // Masters 0 and 2 alternate with no idle cycle
    m_as_ = 4'h0; s_rdy_ = 8'h00;
    m_req_ = 4'b1010;
    cyc();
    for (int j = 0; j < 6; j++) begin
      exp_k  = (j % 2 == 0) ? 2 : 0;
      m_req_ = 4'hF & ~(4'd1 << (2 - exp_k));
      settle();
      check("alt_grnt", g0, 4'hF & ~(4'd1 << exp_k));
      advance();
    end
    s_rdy_ = 8'hFF;
    go_idle();

    // Owner 1 read of slave 2 with three wait states
    m_req_ = 4'b1101;
    cyc();
    m_addr[63:32] = 32'h4000_0010; m_rw[1] = 1'b1; m_as_ = 4'b1101;
    s_rd_data[95:64] = 32'hDEAD_BEEF;
    for (int w = 0; w < 3; w++) begin
      settle();
      check("wait_cs", cs0, 8'hFB);
      check("wait_rdy", rdy0, 1'b1);
      advance();
    end
    s_rdy_[2] = 1'b0;
    settle();
    check("rd_cs", cs0, 8'hFB);
    check("rd_data", rd0, 32'hDEAD_BEEF);
    check("rd_rdy", rdy0, 1'b0);
    check("rd_err", err0, 1'b0);
    advance();
    s_rdy_ = 8'hFF;
    go_idle();

    // Unmapped index on the 5-slave instance
    m_req_ = 4'b1101;
    cyc();
    m_addr[63:32] = 32'hE000_0000; m_as_ = 4'b1101;
    settle();
    check("unmap_cs", cs1, 5'h1F);
    check("unmap_rdy", rdy1, 1'b0);
    check("unmap_err", err1, 1'b1);
    check("map7_cs", cs0, 8'h7F);
    advance();
    go_idle();

    // Timeout of 4 on the 5-slave instance, then slave ready wins the tie
    m_req_ = 4'b1101;
    cyc();
    m_addr[63:32] = 32'h2000_0000; s_rd_data[63:32] = 32'hCAFE_F00D;
    m_as_ = 4'b1101;
    for (int w = 1; w <= 6; w++) begin
      settle();
      check("tmo_err", err1, (w == 5) ? 1'b1 : 1'b0);
      check("tmo_rdy", rdy1, (w == 5) ? 1'b0 : 1'b1);
      advance();
    end
    m_as_ = 4'hF;
    cyc();
    m_as_ = 4'b1101;
    for (int w = 1; w <= 4; w++) cyc();
    s_rdy_[1] = 1'b0;
    settle();
    check("tie_err", err1, 1'b0);
    check("tie_rdy", rdy1, 1'b0);
    check("tie_data", rd1, 32'hCAFE_F00D);
    advance();
    s_rdy_ = 8'hFF;
    go_idle();

    // Reset while master 3 owns the bus mid-access
    m_req_ = 4'b0111;
    cyc();
    m_addr[127:96] = 32'h2000_0000; m_as_ = 4'b0111;
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    settle();
    check("rst_mid_grnt", g0, 4'hF);
    check("rst_mid_as", as0, 1'b1);
    advance();
    settle();
    check("post_rst_grnt", g0, 4'b0111);
    advance();
    go_idle();

    // Random traffic
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 7) == 0) m_req_[i] = ~m_req_[i];
        m_as_[i] = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
        if ($urandom_range(0, 3) == 0) begin
          ix = 3'($urandom_range(0, 7));
          m_addr[i*32 +: 32] = {ix, 29'($urandom)};
        end
        m_rw[i] = 1'($urandom);
        m_wr_data[i*32 +: 32] = $urandom;
      end
      for (int s = 0; s < 8; s++) begin
        s_rdy_[s] = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
        s_rd_data[s*32 +: 32] = $urandom;
      end
      reset = ($urandom_range(0, 299) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_matrix_rr.md
Name: bus_matrix_rr

Overview:
Parametrised successor to the fixed 4-master/8-slave bus arbiter and decoder used in the SoC top level.
- Arbitrates NUM_M active-low-request masters with registered round-robin grant.
- Decodes the owner's address into NUM_S active-low slave chip selects and returns the selected slave's read data and ready.
- Adds an error response for unmapped slave indices and a per-access wait-state timeout; neither exists in the previous generation.

Parameters:
NUM_M, 4, number of bus masters (2..8)
NUM_S, 8, number of slaves (1..16)
ADDR_W, 32, address width
DATA_W, 32, data width
SEL_LO, 29, LSB of the slave-index field in the address; field width is clog2(NUM_S), minimum 1
TIMEOUT, 255, max wait cycles before an error response; 0 disables the timeout

Ports:
clk  in  1  clock; all state changes on its rising edge
reset  in  1  synchronous, active-high reset
m_req_  in  NUM_M  per-master bus request, active low
m_addr  in  NUM_M*ADDR_W  per-master address, master i at [i*ADDR_W +: ADDR_W]
m_as_  in  NUM_M  per-master address strobe, active low
m_rw  in  NUM_M  per-master read/write flag (READ=1, WRITE=0, per stddef)
m_wr_data  in  NUM_M*DATA_W  per-master write data
m_grnt_  out  NUM_M  per-master grant, active low, at most one asserted
m_rd_data  out  DATA_W  read data returned to masters (shared)
m_rdy_  out  1  access complete, active low (shared)
m_err  out  1  error response qualifier, high together with m_rdy_ low
s_addr  out  ADDR_W  owner address
s_as_  out  1  owner address strobe, active low
s_rw  out  1  owner read/write flag
s_wr_data  out  DATA_W  owner write data
s_cs_  out  NUM_S  slave chip selects, active low, one-hot or all high
s_rd_data  in  NUM_S*DATA_W  per-slave read data
s_rdy_  in  NUM_S  per-slave ready, active low

Behaviour:
- State: owner_vld (1b), owner (clog2 NUM_M), last-grant pointer, wait counter (clog2(TIMEOUT+1)).
- Reset:
  - m_grnt_ all 1, owner_vld 0, pointer = NUM_M-1, counter 0.
  - Hence s_as_=1, s_addr=0, s_wr_data=0, s_rw=READ, s_cs_ all 1, m_rdy_=1, m_err=0, m_rd_data=0.
- FSM IDLE (owner_vld=0): if any m_req_ low, register the next requester in round-robin order starting at pointer+1 (mod NUM_M). Grant rises one cycle after the request (m_grnt_[k] low from the next edge). Pointer := k.
- FSM OWNED: grant held while m_req_[owner] low.
- Release:
  - When m_req_[owner] is high at an edge, the grant drops at that edge.
  - If other requests are pending in the same cycle, the next grant is issued at that same edge (no idle cycle), searched from owner+1.
  - The releasing master has the lowest priority.
- Datapath mux is combinational from the registered owner. When owner_vld=0, s_as_=1 and the other s_* outputs are 0/READ.
- Decode: idx = s_addr[SEL_LO +: SW].
  - s_cs_[idx]=0 only when owner_vld and idx<NUM_S.
  - m_rd_data = s_rd_data[idx] and m_rdy_ = s_rdy_[idx] when the chip select is active; otherwise m_rdy_=1 and m_rd_data=0.
- Unmapped (owner_vld, s_as_=0, idx>=NUM_S): m_rdy_=0 and m_err=1 combinationally in that cycle; no chip select is asserted.
- Timeout (TIMEOUT>0):
  - Counter increments each cycle with s_as_=0, a chip select active and the selected s_rdy_=1.
  - Counter clears on selected s_rdy_=0, on s_as_=1, or on an owner change.
  - When counter==TIMEOUT: m_rdy_=0, m_err=1 for exactly that cycle, then the counter clears.
  - A slave ready arriving in the same cycle wins: m_err=0, data from the slave.
- m_err is 0 whenever m_rdy_ is 1.
- Reset asserted mid-access: all grants drop and the counter clears at that edge. No completion is signalled for the aborted access.
- Masters may hold m_as_ low across back-to-back accesses; each s_rdy_ low cycle completes one access.

Decomposition:
- Shared header (extending head/stddef.v): ENABLE_/DISABLE_, READ/WRITE, WORD_ADDR_W/WORD_DATA_W defaults, plus a clog2 function macro.
- One sub-module, rr_arbiter (NUM_M): request vector, release and pointer in; registered one-hot grant out.
- Decode, mux and timeout stay in bus_matrix_rr.

Test Plan:
- Reset, then m_req_=4'b1110 -> m_grnt_=4'b1110 exactly one cycle later; all outputs at reset values before that.
- Masters 0 and 2 requesting continuously, each releasing after one access -> grants alternate 0,2,0,2 with no idle cycle between owners.
- Owner 1 reads addr 32'h4000_0010 (idx 2), slave 2 ready after 3 wait cycles with data 32'hDEAD_BEEF -> s_cs_=8'hFB, m_rd_data=DEAD_BEEF, m_rdy_=0, m_err=0 on the 4th cycle.
- NUM_S=5, access to addr 32'hE000_0000 (idx 7) -> s_cs_ all 1; m_rdy_=0 and m_err=1 in the strobe cycle.
- TIMEOUT=4, selected slave never ready -> m_rdy_=0, m_err=1 on the 5th strobe cycle. Repeat with s_rdy_ low in that exact cycle -> m_err=0 and slave data returned.
- Reset asserted while master 3 is owner mid-access -> m_grnt_=4'hF and s_as_=1 after that edge; the next request after reset is granted normally.
